// File: rtl/alu_pkg.sv
// Shared types for the alu16 execute path: op encodings, flag layout and sequencer states.
package alu_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    HOLD = 2'd3
  } alu_seq_state_e;

  // 001 and 111 have no alu16 meaning
  function automatic logic isIllegal(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b111);
  endfunction

  function automatic logic isArith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu16.sv
// 16-bit combinational ALU slice; exposes carry into and out of the MSB so callers can chain and flag.
module alu16
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  input  logic              cIn,
  output logic [DATA_W-1:0] y,
  output logic              cOut,
  output logic              cInMSB
);

  logic [DATA_W-1:0] bOp;
  logic [DATA_W-1:0] lowSum;
  logic [1:0]        msbSum;

  // SUB is A + ~B + cIn; the caller supplies cIn=1 on the first pass
  assign bOp    = (ctrl == OP_SUB) ? ~b : b;
  assign lowSum = {1'b0, a[DATA_W-2:0]} + {1'b0, bOp[DATA_W-2:0]} + {{(DATA_W-1){1'b0}}, cIn};
  assign msbSum = {1'b0, a[DATA_W-1]} + {1'b0, bOp[DATA_W-1]} + {1'b0, lowSum[DATA_W-1]};

  always_comb begin
    y      = '0;
    cOut   = 1'b0;
    cInMSB = 1'b0;
    case (ctrl)
      OP_PASS_B: y = b;
      OP_ADD, OP_SUB: begin
        y      = {msbSum[0], lowSum[DATA_W-2:0]};
        cOut   = msbSum[1];
        cInMSB = lowSum[DATA_W-1];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq32.sv
// Execute-stage sequencer: runs one alu16 for one (narrow) or two (wide, carry-chained) passes
// and holds the result with N/Z/C/V flags until writeback accepts it.
module alu_seq32
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_wide,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  alu_seq_state_e state, nextState;

  logic [2:0]        op_p0;
  logic              wide_p0;
  logic [31:0]       a_p0;
  logic [31:0]       b_p0;
  logic [TAG_W-1:0]  tag_p0;

  logic [DATA_W-1:0] loRes_p1;
  logic              loCout_p1;

  logic [DATA_W-1:0] aluA, aluB, aluY;
  logic              aluCin, aluCout, aluCinMsb;
  logic              illegal, arith;

  alu_flags_t        outFlags;

  function automatic alu_flags_t calcFlags(input logic [31:0] res, input logic wide,
                                           input logic arithOp, input logic cOut,
                                           input logic cInMsb);
    alu_flags_t f;
    f.n = wide ? res[31] : res[15];
    f.z = wide ? (res == 32'd0) : (res[15:0] == 16'd0);
    f.c = arithOp & cOut;
    f.v = arithOp & (cOut ^ cInMsb);
    return f;
  endfunction

  assign illegal   = isIllegal(op_p0);
  assign arith     = isArith(op_p0);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign out_flags = outFlags;

  // The single alu16 is shared: low halves in LO, high halves in HI
  assign aluA   = (state == HI) ? a_p0[31:16] : a_p0[15:0];
  assign aluB   = (state == HI) ? b_p0[31:16] : b_p0[15:0];
  assign aluCin = (state == HI) ? (arith & loCout_p1) : op_p0[0];

  alu16 uAlu (
    .a      (aluA),
    .b      (aluB),
    .ctrl   (op_p0),
    .cIn    (aluCin),
    .y      (aluY),
    .cOut   (aluCout),
    .cInMSB (aluCinMsb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = LO;
      LO:      nextState = (wide_p0 && !illegal) ? HI : HOLD;
      HI:      nextState = HOLD;
      HOLD:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // p0: operand capture on accept
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      op_p0   <= in_op;
      wide_p0 <= in_wide;
      a_p0    <= in_a;
      b_p0    <= in_b;
      tag_p0  <= in_tag;
    end
  end

  // p1: low-half result and carry for the high pass
  always_ff @(posedge clk) begin
    if (state == LO) begin
      loRes_p1  <= aluY;
      loCout_p1 <= aluCout;
    end
  end

  // p2: result/flags registered on entry to HOLD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_result <= '0;
      outFlags   <= '0;
      out_err    <= 1'b0;
      out_tag    <= '0;
    end else if (state == LO && nextState == HOLD) begin
      out_tag <= tag_p0;
      out_err <= illegal;
      if (illegal) begin
        out_result <= '0;
        outFlags   <= '0;
      end else begin
        out_result <= {16'd0, aluY};
        outFlags   <= calcFlags({16'd0, aluY}, 1'b0, arith, aluCout, aluCinMsb);
      end
    end else if (state == HI) begin
      out_tag    <= tag_p0;
      out_err    <= 1'b0;
      out_result <= {aluY, loRes_p1};
      outFlags   <= calcFlags({aluY, loRes_p1}, 1'b1, arith, aluCout, aluCinMsb);
    end
  end

endmodule

// File: tb/tb_alu_seq32.sv
// Directed scoreboard bench for alu_seq32: reference model computes full-width results and flags.
module tb_alu_seq32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_wide;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;
  logic [3:0]  out_tag;

  int testCnt = 0;
  int failCnt = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
    logic [3:0]  tag;
    int          lat;
  } expT;

  expT expQ[$];

  always #5 clk = ~clk;

  alu_seq32 #(.TAG_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_wide    (in_wide),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_err    (out_err),
    .out_tag    (out_tag)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    assert (got === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  function automatic expT model(input logic [2:0] op, input logic wide, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] tag);
    expT e;
    logic [32:0] s;
    logic [31:0] aa, bb, r;
    logic        n, z, c, v;
    int          msb;
    msb = wide ? 31 : 15;
    aa  = wide ? a : {16'd0, a[15:0]};
    bb  = wide ? b : {16'd0, b[15:0]};
    c = 1'b0; v = 1'b0; r = '0;
    e.err = 1'b0;
    case (op)
      3'b000: r = bb;
      3'b010: begin
        s = wide ? ({1'b0, aa} + {1'b0, bb}) : ({17'd0, aa[15:0]} + {17'd0, bb[15:0]});
        r = wide ? s[31:0] : {16'd0, s[15:0]};
        c = wide ? s[32] : s[16];
        v = (aa[msb] == bb[msb]) && (r[msb] != aa[msb]);
      end
      3'b011: begin
        s = wide ? ({1'b0, aa} + {1'b0, ~bb} + 33'd1)
                 : ({17'd0, aa[15:0]} + {17'd0, ~bb[15:0]} + 33'd1);
        r = wide ? s[31:0] : {16'd0, s[15:0]};
        c = wide ? s[32] : s[16];
        v = (aa[msb] != bb[msb]) && (r[msb] != aa[msb]);
      end
      3'b100: r = aa & bb;
      3'b101: r = aa | bb;
      3'b110: r = aa ^ bb;
      default: e.err = 1'b1;
    endcase
    n = r[msb];
    z = (r == 32'd0);
    e.res   = r;
    e.flags = e.err ? 4'b0000 : {n, z, c, v};
    e.tag   = tag;
    e.lat   = (wide && !e.err) ? 3 : 2;
    return e;
  endfunction

  task automatic runOp(input string nm, input logic [2:0] op, input logic wide,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input int hold);
    int   waitCyc;
    int   edges;
    expT  e;
    waitCyc = 0;
    while (!in_ready && waitCyc < 20) begin
      @(posedge clk); #1; waitCyc++;
    end
    check({nm, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_wide = wide; in_a = a; in_b = b; in_tag = tag;
    expQ.push_back(model(op, wide, a, b, tag));
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'($urandom); in_wide = 1'($urandom);
    in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1; edges++;
    end
    e = expQ.pop_front();
    check({nm, "_latency"}, edges, e.lat);
    check({nm, "_result"}, out_result, e.res);
    check({nm, "_flags"}, {28'd0, out_flags}, {28'd0, e.flags});
    check({nm, "_err"}, {31'd0, out_err}, {31'd0, e.err});
    check({nm, "_tag"}, {28'd0, out_tag}, {28'd0, e.tag});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({nm, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({nm, "_hold_result"}, out_result, e.res);
      check({nm, "_hold_flags"}, {28'd0, out_flags}, {28'd0, e.flags});
      check({nm, "_hold_tag"}, {28'd0, out_tag}, {28'd0, e.tag});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_release_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({nm, "_release_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_wide = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {28'd0, out_flags}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    runOp("n_add_ovf",  3'b010, 1'b0, 32'h1234_7FFF, 32'hABCD_0001, 4'h1, 0);
    runOp("n_sub_zero", 3'b011, 1'b0, 32'h0000_CCAA, 32'h0000_CCAA, 4'h2, 0);
    runOp("w_add_cy",   3'b010, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 4'h3, 0);
    runOp("w_sub_brw",  3'b011, 1'b1, 32'h0001_0000, 32'h0000_0001, 4'h4, 0);
    runOp("w_xor",      3'b110, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 4'h5, 0);
    runOp("n_and_hold", 3'b100, 1'b0, 32'hFFFF_F0F0, 32'h0000_3C3C, 4'h6, 5);
    runOp("w_or",       3'b101, 1'b1, 32'h1200_0034, 32'h0056_7800, 4'h7, 0);
    runOp("n_passb",    3'b000, 1'b0, 32'h1111_2222, 32'h3333_8444, 4'h8, 0);
    runOp("w_sub_ovf",  3'b011, 1'b1, 32'h8000_0000, 32'h0000_0001, 4'h9, 0);
    runOp("n_sub_neg",  3'b011, 1'b0, 32'h0000_0001, 32'h0000_0002, 4'hA, 0);
    runOp("w_add_zero", 3'b010, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'hB, 0);
    runOp("ill_111",    3'b111, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 4'hC, 0);
    runOp("ill_001",    3'b001, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 4'hD, 0);

    // Reset during the HI pass of a wide op: nothing may come out
    in_valid = 1'b1; in_op = 3'b010; in_wide = 1'b1;
    in_a = 32'h0F0F_0F0F; in_b = 32'h0101_0101; in_tag = 4'hE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2;
    check("midrst_valid_low", {31'd0, out_valid}, 32'd0);
    check("midrst_result_clr", out_result, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    end

    runOp("post_rst",   3'b010, 1'b0, 32'h0000_0005, 32'h0000_0007, 4'hF, 0);

    check("scoreboard_empty", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
